// File: rtl/inst_encoder.sv
// Streaming RV32I instruction encoder: packs fields by type into a 32-bit word,
// flags type/opcode mismatches and misaligned branch/jump offsets, and buffers words in a 2-entry FIFO.
module inst_encoder #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        op_type,
  input  logic [6:0]        opcode,
  input  logic [4:0]        rd,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [2:0]        funct3,
  input  logic [6:0]        funct7,
  input  logic [31:0]       imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_word,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_err,
  output logic [7:0]        err_cnt
);

  typedef enum logic [2:0] {
    TYPE_I = 3'd0,
    TYPE_S = 3'd2,
    TYPE_B = 3'd3,
    TYPE_U = 3'd4,
    TYPE_J = 3'd5,
    TYPE_R = 3'd6
  } op_type_e;

  localparam logic [31:0] NOP = 32'h0000_0013;

  op_type_e    exp_type;
  logic        known_op;
  logic        type_legal;
  logic        enc_err;
  logic [31:0] packed_word;
  logic [31:0] enc_word;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    exp_type = TYPE_I;
    known_op = 1'b1;
    case (opcode)
      7'b0110011:                         exp_type = TYPE_R;
      7'b0010011, 7'b1100111, 7'b1110011: exp_type = TYPE_I;
      7'b0100011:                         exp_type = TYPE_S;
      7'b1100011:                         exp_type = TYPE_B;
      7'b1101111:                         exp_type = TYPE_J;
      7'b0110111, 7'b0010111:             exp_type = TYPE_U;
      default:                            known_op = 1'b0;
    endcase
  end

  assign type_legal = (op_type != 3'd1) && (op_type != 3'd7);
  assign enc_err    = !type_legal || !known_op || (op_type != exp_type) ||
                      (((op_type == TYPE_B) || (op_type == TYPE_J)) && imm[0]);

  always_comb begin
    packed_word = NOP;
    case (op_type)
      TYPE_R: packed_word = {funct7, rs2, rs1, funct3, rd, opcode};
      TYPE_I: packed_word = {imm[11:0], rs1, funct3, rd, opcode};
      TYPE_S: packed_word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
      TYPE_B: packed_word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
      TYPE_U: packed_word = {imm[31:12], rd, opcode};
      TYPE_J: packed_word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
      default: packed_word = NOP;
    endcase
  end

  assign enc_word = enc_err ? NOP : packed_word;

  logic [31:0]       mem_word [2];
  logic [ADDR_W-1:0] mem_addr [2];
  logic              mem_err  [2];
  logic              wr_ptr;
  logic              rd_ptr;
  logic [1:0]        count;
  logic [ADDR_W-1:0] wr_addr;
  logic              push;
  logic              pop;

  assign in_ready  = (count < 2'd2);
  assign out_valid = (count != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // NOTE: FIFO storage has no reset; out_* are gated by out_valid so stale entries never show.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_word[wr_ptr] <= enc_word;
      mem_addr[wr_ptr] <= wr_addr;
      mem_err[wr_ptr]  <= enc_err;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= 1'b0;
      rd_ptr  <= 1'b0;
      count   <= 2'd0;
      wr_addr <= '0;
      err_cnt <= 8'd0;
    end else begin
      if (push) begin
        wr_ptr  <= ~wr_ptr;
        wr_addr <= wr_addr + ADDR_W'(1);
        if (enc_err && (err_cnt != 8'hFF))
          err_cnt <= err_cnt + 8'd1;
      end
      if (pop)
        rd_ptr <= ~rd_ptr;
      if (push && !pop)
        count <= count + 2'd1;
      else if (!push && pop)
        count <= count - 2'd1;
    end
  end

  assign out_word = out_valid ? mem_word[rd_ptr] : '0;
  assign out_addr = out_valid ? mem_addr[rd_ptr] : '0;
  assign out_err  = out_valid ? mem_err[rd_ptr]  : 1'b0;

endmodule

// File: tb/tb_inst_encoder.sv
// Self-checking bench for inst_encoder: directed encodings plus randomized streaming
// against a field-level reference model and a 2-deep queue scoreboard.
module tb_inst_encoder;

  typedef struct {
    logic [2:0]  t;
    logic [6:0]  opc;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
  } fields_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  op_type;
  logic [6:0]  opcode;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_word;
  logic [7:0]  out_addr;
  logic        out_err;
  logic [7:0]  err_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  logic [32:0] exp_q[$];
  int          addr_q[$];
  int          m_addr = 0;
  int          m_err_cnt = 0;

  inst_encoder #(.ADDR_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op_type(op_type), .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2),
    .funct3(funct3), .funct7(funct7), .imm(imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_word(out_word),
    .out_addr(out_addr), .out_err(out_err), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
  endtask

  task automatic finish_sim();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  endtask

  function automatic logic [31:0] bits(logic [31:0] x, int hi, int lo);
    return (x >> lo) & ((32'd1 << (hi - lo + 1)) - 32'd1);
  endfunction

  // Reference: returns {err, word}, built from the field layout tables with shifts.
  function automatic logic [32:0] ref_encode(fields_t f);
    int          want;
    bit          bad;
    logic [31:0] w;
    case (f.opc)
      7'b0110011:                         want = 6;
      7'b0010011, 7'b1100111, 7'b1110011: want = 0;
      7'b0100011:                         want = 2;
      7'b1100011:                         want = 3;
      7'b1101111:                         want = 5;
      7'b0110111, 7'b0010111:             want = 4;
      default:                            want = -1;
    endcase
    bad = (want < 0) || (int'(f.t) != want) || ((f.t == 3 || f.t == 5) && f.imm[0]);
    w = 32'(f.opc);
    case (f.t)
      6: w |= (32'(f.f7) << 25) | (32'(f.rs2) << 20) | (32'(f.rs1) << 15) | (32'(f.f3) << 12) | (32'(f.rd) << 7);
      0: w |= (bits(f.imm, 11, 0) << 20) | (32'(f.rs1) << 15) | (32'(f.f3) << 12) | (32'(f.rd) << 7);
      2: w |= (bits(f.imm, 11, 5) << 25) | (32'(f.rs2) << 20) | (32'(f.rs1) << 15) | (32'(f.f3) << 12)
              | (bits(f.imm, 4, 0) << 7);
      3: w |= (bits(f.imm, 12, 12) << 31) | (bits(f.imm, 10, 5) << 25) | (32'(f.rs2) << 20)
              | (32'(f.rs1) << 15) | (32'(f.f3) << 12) | (bits(f.imm, 4, 1) << 8) | (bits(f.imm, 11, 11) << 7);
      4: w |= (f.imm & 32'hFFFF_F000) | (32'(f.rd) << 7);
      5: w |= (bits(f.imm, 20, 20) << 31) | (bits(f.imm, 10, 1) << 21) | (bits(f.imm, 11, 11) << 20)
              | (bits(f.imm, 19, 12) << 12) | (32'(f.rd) << 7);
      default: ;
    endcase
    if (bad) return {1'b1, 32'h0000_0013};
    return {1'b0, w};
  endfunction

  function automatic fields_t mk(int t, logic [6:0] opc, int rd_i, int rs1_i, int rs2_i,
                                 int f3_i, int f7_i, logic [31:0] imm_i);
    fields_t f;
    f.t = 3'(t); f.opc = opc; f.rd = 5'(rd_i); f.rs1 = 5'(rs1_i); f.rs2 = 5'(rs2_i);
    f.f3 = 3'(f3_i); f.f7 = 7'(f7_i); f.imm = imm_i;
    return f;
  endfunction

  function automatic fields_t rand_fields();
    fields_t f;
    int      k;
    f = mk(0, 7'd0, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom);
    k = $urandom_range(0, 11);
    case (k)
      0: begin f.t = 6; f.opc = 7'b0110011; end
      1: begin f.t = 0; f.opc = 7'b0010011; end
      2: begin f.t = 0; f.opc = 7'b1100111; end
      3: begin f.t = 0; f.opc = 7'b1110011; end
      4: begin f.t = 2; f.opc = 7'b0100011; end
      5: begin f.t = 3; f.opc = 7'b1100011; f.imm[0] = 1'b0; end
      6: begin f.t = 5; f.opc = 7'b1101111; f.imm[0] = 1'b0; end
      7: begin f.t = 4; f.opc = 7'b0110111; end
      8: begin f.t = 4; f.opc = 7'b0010111; end
      9: begin f.t = 3'($urandom_range(2, 3)) + 3'd1; f.opc = (f.t == 3) ? 7'b1100011 : 7'b1101111; end
      default: begin f.t = 3'($urandom); f.opc = 7'($urandom); end
    endcase
    return f;
  endfunction

  // Scoreboard: checks state before this cycle's edge, then records the transfers the edge will make.
  always @(negedge clk) begin
    fields_t     f;
    logic [32:0] e;
    if (rst) begin
      exp_q.delete();
      addr_q.delete();
      m_addr    = 0;
      m_err_cnt = 0;
    end else begin
      check("in_ready", 32'(in_ready), 32'(exp_q.size() < 2));
      check("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
      check("err_cnt", 32'(err_cnt), 32'(m_err_cnt));
      if (out_valid && exp_q.size() != 0) begin
        check("sb_word", out_word, exp_q[0][31:0]);
        check("sb_err", 32'(out_err), 32'(exp_q[0][32]));
        check("sb_addr", 32'(out_addr), 32'(addr_q[0]));
        if (out_ready) begin
          void'(exp_q.pop_front());
          void'(addr_q.pop_front());
        end
      end
      if (in_valid && in_ready) begin
        f = mk(op_type, opcode, rd, rs1, rs2, funct3, funct7, imm);
        e = ref_encode(f);
        exp_q.push_back(e);
        addr_q.push_back(m_addr);
        m_addr = (m_addr + 1) % 256;
        if (e[32] && m_err_cnt < 255) m_err_cnt++;
      end
    end
  end

  task automatic drive(fields_t f);
    op_type = f.t; opcode = f.opc; rd = f.rd; rs1 = f.rs1; rs2 = f.rs2;
    funct3 = f.f3; funct7 = f.f7; imm = f.imm;
  endtask

  // Called at posedge+1; returns at posedge+1 right after the word was accepted.
  task automatic send(fields_t f, bit rnd);
    drive(f);
    in_valid = 1'b1;
    for (int k = 0; ; k++) begin
      if (rnd) out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (in_ready) break;
      if (k == 60) begin
        check("send_timeout", 32'd0, 32'd1);
        finish_sim();
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(int n);
    in_valid = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; ; k++) begin
      @(negedge clk);
      if (!out_valid) break;
      if (k == 10) begin
        check("drain_timeout", 32'd0, 32'd1);
        finish_sim();
      end
    end
    @(posedge clk); #1;
  endtask

  initial begin
    time t0;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    drive(mk(0, 7'd0, 0, 0, 0, 0, 0, 32'd0));
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_word", out_word, 32'd0);
    check("rst_out_addr", 32'(out_addr), 32'd0);
    check("rst_out_err", 32'(out_err), 32'd0);
    check("rst_err_cnt", 32'(err_cnt), 32'd0);

    send(mk(0, 7'b0010011, 1, 0, 0, 0, 0, 32'd5), 0);
    check("addi_word", out_word, 32'h0050_0093);
    check("addi_addr", 32'(out_addr), 32'd0);
    send(mk(6, 7'b0110011, 3, 1, 2, 0, 0, 32'd0), 0);
    check("add_word", out_word, 32'h0020_81B3);
    check("add_addr", 32'(out_addr), 32'd1);
    send(mk(2, 7'b0100011, 0, 1, 2, 2, 0, 32'd8), 0);
    check("sw_word", out_word, 32'h0020_A423);
    check("sw_addr", 32'(out_addr), 32'd2);
    send(mk(3, 7'b1100011, 0, 1, 2, 0, 0, -32'sd4), 0);
    check("beq_word", out_word, 32'hFE20_8EE3);
    check("beq_err", 32'(out_err), 32'd0);
    send(mk(5, 7'b1101111, 1, 0, 0, 0, 0, 32'd8), 0);
    check("jal_word", out_word, 32'h0080_00EF);
    check("jal_err", 32'(out_err), 32'd0);
    send(mk(4, 7'b0110111, 5, 0, 0, 0, 0, 32'h1234_5000), 0);
    check("lui_word", out_word, 32'h1234_52B7);
    check("lui_err", 32'(out_err), 32'd0);

    send(mk(6, 7'b0010011, 1, 2, 3, 0, 0, 32'd0), 0);
    check("mismatch_word", out_word, 32'h0000_0013);
    check("mismatch_err", 32'(out_err), 32'd1);
    check("mismatch_cnt", 32'(err_cnt), 32'd1);
    send(mk(3, 7'b1100011, 0, 1, 2, 0, 0, 32'd3), 0);
    check("b_odd_word", out_word, 32'h0000_0013);
    check("b_odd_cnt", 32'(err_cnt), 32'd2);
    send(mk(7, 7'b0010011, 1, 0, 0, 0, 0, 32'd1), 0);
    check("type7_err", 32'(out_err), 32'd1);
    check("type7_cnt", 32'(err_cnt), 32'd3);
    idle(2);

    // Backpressure: three words offered back to back with the consumer stalled.
    out_ready = 1'b0;
    drive(mk(0, 7'b0010011, 7, 1, 0, 0, 0, 32'd11)); in_valid = 1'b1;
    @(negedge clk); check("bp_rdy0", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    drive(mk(0, 7'b0010011, 8, 1, 0, 0, 0, 32'd12));
    @(negedge clk); check("bp_rdy1", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    drive(mk(0, 7'b0010011, 9, 1, 0, 0, 0, 32'd13));
    @(negedge clk);
    check("bp_rdy2", 32'(in_ready), 32'd0);
    check("bp_head", out_word, 32'h00B0_8393);
    @(posedge clk); #1;
    check("bp_hold_word", out_word, 32'h00B0_8393);
    check("bp_hold_addr", 32'(out_addr), 32'd9);
    out_ready = 1'b1;
    send(mk(0, 7'b0010011, 9, 1, 0, 0, 0, 32'd13), 0);
    drain();

    // Reset with two words buffered.
    out_ready = 1'b0;
    send(rand_fields(), 0);
    send(rand_fields(), 0);
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    check("mid_rst_err_cnt", 32'(err_cnt), 32'd0);
    out_ready = 1'b1;
    send(mk(0, 7'b0010011, 1, 0, 0, 0, 0, 32'd5), 0);
    check("mid_rst_addr", 32'(out_addr), 32'd0);

    // Randomized streaming with random backpressure and gaps.
    for (int i = 0; i < 400; i++) begin
      send(rand_fields(), 1);
      if ($urandom_range(0, 7) == 0) idle($urandom_range(1, 3));
    end
    drain();

    // Full-rate stream across the address wrap.
    rst = 1'b1; in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    t0 = $time;
    for (int i = 0; i < 256; i++) send(mk(0, 7'b0010011, i % 32, 0, 0, 0, 0, 32'(i)), 0);
    check("throughput_cycles", 32'(($time - t0) / 10), 32'd256);
    send(mk(0, 7'b0010011, 2, 0, 0, 0, 0, 32'd257), 0);
    check("wrap_addr", 32'(out_addr), 32'd0);
    idle(1);

    for (int i = 0; i < 300; i++) send(mk(7, 7'($urandom), 0, 0, 0, 0, 0, 32'd0), 0);
    idle(2);
    check("sat_err_cnt", 32'(err_cnt), 32'd255);
    drain();

    finish_sim();
  end

  initial begin
    #500000;
    check("global_timeout", 32'd0, 32'd1);
    finish_sim();
  end

endmodule

// File: doc/inst_encoder.md
# inst_encoder

Streaming RV32I instruction encoder for the FPGA test harness. It is the inverse of the opcode-to-type decode: it accepts instruction fields plus a type code, packs them into a 32-bit instruction word and emits the word on a valid/ready stream. The stream carries a running word address for loading instruction memory. A 2-entry output buffer provides full throughput under backpressure. Type/opcode mismatches and misaligned branch/jump immediates are flagged and replaced by a NOP.

## Interface
- ADDR_W, 8: width of the word-address counter `out_addr`.
- clk  input  1  clock; all logic on its rising edge.
- rst  input  1  reset, synchronous, active-high.
- in_valid  input  1  field set present.
- in_ready  output  1  encoder can accept; transfer when in_valid && in_ready.
- op_type  input  3  I=0, S=2, B=3, U=4, J=5, R=6; values 1 and 7 are illegal.
- opcode  input  7  RV32I major opcode.
- rd, rs1, rs2  input  5 each  register indices.
- funct3  input  3  function field.
- funct7  input  7  R-type function field.
- imm  input  32  immediate, already sign-extended; U-type uses imm[31:12].
- out_valid  output  1  word available.
- out_ready  input  1  consumer accepts; transfer when out_valid && out_ready.
- out_word  output  32  encoded instruction.
- out_addr  output  ADDR_W  word index of out_word.
- out_err  output  1  word was substituted due to an error.
- err_cnt  output  8  saturating count of errored words accepted.

## Operation
- Expected type per opcode:
  - 0110011 → R.
  - 0010011, 1100111, 1110011 → I.
  - 0100011 → S.
  - 1100011 → B.
  - 1101111 → J.
  - 0110111, 0010111 → U.
  - Any other opcode is unknown.
- Error conditions: illegal op_type, unknown opcode, op_type ≠ expected type, or (B or J and imm[0]=1).
- Error handling: out_word = 0x00000013 (NOP), out_err=1, and err_cnt increments, saturating at 255.
- Packing, MSB to LSB:
  - R: funct7|rs2|rs1|funct3|rd|opcode.
  - I: imm[11:0]|rs1|funct3|rd|opcode.
  - S: imm[11:5]|rs2|rs1|funct3|imm[4:0]|opcode.
  - B: imm[12]|imm[10:5]|rs2|rs1|funct3|imm[4:1]|imm[11]|opcode.
  - U: imm[31:12]|rd|opcode.
  - J: imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd|opcode.
- Fields not used by a type are ignored, and upper imm bits beyond the field are ignored.
- Encoding is combinational on the input. The result, its address and its error bit are written into a 2-entry FIFO on input transfer; the FIFO head drives out_*.
- Address counter: a write-side address counter is captured with each entry, then incremented on each input transfer, wrapping modulo 2^ADDR_W.
- in_ready = FIFO count < 2. It is registered-equivalent: it depends only on count, not on out_ready.
- Simultaneous input and output transfer: count is unchanged; ordering is preserved.

## Timing
- Reset values: in_ready=1, out_valid=0, out_word=0, out_addr=0, out_err=0, err_cnt=0, FIFO count=0, address counter=0.
- Reset asserted mid-stream discards buffered words. The first word accepted after reset gets out_addr=0.
- Latency: a word accepted in cycle N is visible on out_* from cycle N+1 if the FIFO was empty.
- Throughput: 1 word/cycle when out_ready is held at 1.
- Output stability: while out_valid=1 && out_ready=0, out_word, out_addr and out_err are held stable.
- With the FIFO full (count=2), in_ready=0. Input presented in that cycle is not accepted and the address counter does not advance.
- With the FIFO empty, out_valid=0 and out_ready is ignored.
- Address counter wrap: with ADDR_W=8, the word after address 255 carries out_addr=0.

## Test plan
- I/R/S encoding, out_ready=1:
  - addi x1,x0,5 (type 0, opcode 0010011, rd=1, imm=5) → out_word 0x00500093, out_addr 0.
  - add x3,x1,x2 → 0x002081B3, out_addr 1.
  - sw x2,8(x1) (funct3=2) → 0x0020A423, out_addr 2.
- B/J/U encoding:
  - beq x1,x2,imm=-4 → 0xFE208EE3.
  - jal x1,imm=8 → 0x008000EF.
  - lui x5,imm=0x12345000 → 0x123452B7.
  - All three have out_err=0.
- Errors:
  - op_type=6 with opcode 0010011 → out_word 0x00000013, out_err=1, err_cnt=1.
  - B-type with imm=3 → NOP, out_err=1, err_cnt=2.
  - op_type=7 → NOP, out_err=1, err_cnt=3.
- Backpressure:
  - out_ready=0, in_valid=1 for 3 cycles → two words accepted and in_ready=0 from cycle 2; the third word is held until out_ready=1.
  - All three words then appear in order with consecutive out_addr.
- Reset mid-stream: two words buffered, rst=1 for 1 cycle → out_valid=0, in_ready=1, err_cnt=0; the next accepted word has out_addr=0.
- Wrap and saturation:
  - 256 streamed words; the 257th has out_addr=0.
  - 300 errored words → err_cnt holds 255.
